// File: rtl/disparity_pkg.sv
// Shared parameters and types for the disparity sweep stream
// (used by disparity_counter and disparity_selector).
package disparity_pkg;

    localparam int WIDTH      = 640;
    localparam int DISP_W     = 6;
    localparam int COST_W     = 16;
    localparam int PIX_W      = 10;
    localparam int NUM_CAND   = 4;
    localparam int NUM_PASSES = 16;
    localparam int LINE_GAP   = 4;

    typedef logic [DISP_W-1:0] disp_t;
    typedef logic [COST_W-1:0] cost_t;
    typedef logic [PIX_W-1:0]  pix_t;

    typedef struct packed {
        disp_t disp;
        cost_t cost;
    } entry_t;

    function automatic logic pixel_in_range(input pix_t p);
        return (p < pix_t'(WIDTH));
    endfunction

endpackage

// File: rtl/disparity_selector_if.sv
// Candidate stream in, depth-map line out, plus the sticky protocol flag.
interface disparity_selector_if;
    import disparity_pkg::*;

    logic  valid;
    pix_t  pixel;
    disp_t disparity_1;
    disp_t disparity_2;
    disp_t disparity_3;
    disp_t disparity_4;
    cost_t cost_1;
    cost_t cost_2;
    cost_t cost_3;
    cost_t cost_4;
    logic  clear_buffer;

    logic  out_valid;
    pix_t  out_pixel;
    disp_t out_disparity;
    cost_t out_cost;
    logic  out_last;
    logic  protocol_error;

    modport master (
        output valid, pixel, disparity_1, disparity_2, disparity_3, disparity_4,
               cost_1, cost_2, cost_3, cost_4, clear_buffer,
        input  out_valid, out_pixel, out_disparity, out_cost, out_last, protocol_error
    );

    modport slave (
        input  valid, pixel, disparity_1, disparity_2, disparity_3, disparity_4,
               cost_1, cost_2, cost_3, cost_4, clear_buffer,
        output out_valid, out_pixel, out_disparity, out_cost, out_last, protocol_error
    );

endinterface

// File: rtl/min_cost_4.sv
// Combinational 4-way argmin over candidate costs; ties resolve to the
// lowest-index candidate, which is also the lowest disparity.
module min_cost_4
    import disparity_pkg::*;
(
    input  disp_t disparity_1,
    input  disp_t disparity_2,
    input  disp_t disparity_3,
    input  disp_t disparity_4,
    input  cost_t cost_1,
    input  cost_t cost_2,
    input  cost_t cost_3,
    input  cost_t cost_4,
    output disp_t min_disparity,
    output cost_t min_cost
);

    disp_t lo_disp_s;
    cost_t lo_cost_s;
    disp_t hi_disp_s;
    cost_t hi_cost_s;

    // Each pick keeps the lower-index side unless the other side is strictly cheaper.
    always_comb begin
        lo_disp_s     = disparity_1;
        lo_cost_s     = cost_1;
        hi_disp_s     = disparity_3;
        hi_cost_s     = cost_3;
        min_disparity = disparity_1;
        min_cost      = cost_1;

        if (cost_2 < cost_1) begin
            lo_disp_s = disparity_2;
            lo_cost_s = cost_2;
        end else begin
            lo_disp_s = disparity_1;
            lo_cost_s = cost_1;
        end

        if (cost_4 < cost_3) begin
            hi_disp_s = disparity_4;
            hi_cost_s = cost_4;
        end else begin
            hi_disp_s = disparity_3;
            hi_cost_s = cost_3;
        end

        if (hi_cost_s < lo_cost_s) begin
            min_disparity = hi_disp_s;
            min_cost      = hi_cost_s;
        end else begin
            min_disparity = lo_disp_s;
            min_cost      = lo_cost_s;
        end
    end

endmodule

// File: rtl/disparity_selector.sv
// Winner-take-all disparity selection: keeps the running minimum cost per
// pixel in a line buffer and streams the winners out during clear_buffer.
module disparity_selector
    import disparity_pkg::*;
(
    input logic           clock,
    input logic           reset_n,
    disparity_selector_if.slave bus
);

    disp_t  min_disp_s;
    cost_t  min_cost_s;
    logic   accept_s;
    logic   violation_s;
    logic   rd_en_s;
    pix_t   rd_addr_s;

    entry_t mem_q [WIDTH];

    logic   s1_valid_q, s1_valid_d;
    logic   s1_first_q, s1_first_d;
    pix_t   s1_pixel_q, s1_pixel_d;
    entry_t s1_entry_q, s1_entry_d;
    entry_t rd_data_q, rd_data_d;
    logic   wr_en_q, wr_en_d;
    pix_t   wr_addr_q, wr_addr_d;
    entry_t wr_data_q, wr_data_d;
    pix_t   rd_cnt_q, rd_cnt_d;
    logic   out_valid_q, out_valid_d;
    pix_t   out_pixel_q, out_pixel_d;
    logic   out_last_q, out_last_d;
    logic   protocol_error_q, protocol_error_d;

    min_cost_4 u_min (
        .disparity_1   (bus.disparity_1),
        .disparity_2   (bus.disparity_2),
        .disparity_3   (bus.disparity_3),
        .disparity_4   (bus.disparity_4),
        .cost_1        (bus.cost_1),
        .cost_2        (bus.cost_2),
        .cost_3        (bus.cost_3),
        .cost_4        (bus.cost_4),
        .min_disparity (min_disp_s),
        .min_cost      (min_cost_s)
    );

    // Qualify input samples and share the single read port; readout owns it during clear_buffer.
    always_comb begin
        accept_s    = bus.valid && !bus.clear_buffer && pixel_in_range(bus.pixel);
        violation_s = bus.valid && (bus.clear_buffer || !pixel_in_range(bus.pixel));
        rd_en_s     = 1'b0;
        rd_addr_s   = bus.pixel;
        if (bus.clear_buffer) begin
            rd_en_s   = 1'b1;
            rd_addr_s = rd_cnt_q;
        end else begin
            rd_en_s   = accept_s;
            rd_addr_s = bus.pixel;
        end
    end

    // Next-state for the update pipeline, the readout counter and the output stage.
    always_comb begin
        s1_valid_d = accept_s;
        s1_first_d = (bus.disparity_1 == {DISP_W{1'b0}});
        s1_pixel_d = bus.pixel;
        s1_entry_d = '{disp: min_disp_s, cost: min_cost_s};

        rd_data_d = rd_data_q;
        if (rd_en_s) begin
            rd_data_d = mem_q[rd_addr_s];
        end else begin
            rd_data_d = rd_data_q;
        end

        // Strict less-than lets the earlier (lower) disparity keep a tie.
        wr_en_d   = s1_valid_q && (s1_first_q || (s1_entry_q.cost < rd_data_q.cost));
        wr_addr_d = s1_pixel_q;
        wr_data_d = s1_entry_q;

        rd_cnt_d    = {PIX_W{1'b0}};
        out_valid_d = bus.clear_buffer;
        out_pixel_d = {PIX_W{1'b0}};
        out_last_d  = 1'b0;
        if (bus.clear_buffer) begin
            if (rd_cnt_q == pix_t'(WIDTH - 1)) begin
                rd_cnt_d = {PIX_W{1'b0}};
            end else begin
                rd_cnt_d = rd_cnt_q + 10'd1;
            end
            out_pixel_d = rd_cnt_q;
            out_last_d  = (rd_cnt_q == pix_t'(WIDTH - 1));
        end else begin
            rd_cnt_d    = {PIX_W{1'b0}};
            out_pixel_d = {PIX_W{1'b0}};
            out_last_d  = 1'b0;
        end

        protocol_error_d = protocol_error_q || violation_s;
    end

    // Pipeline, readout and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_q       <= 1'b0;
            s1_first_q       <= 1'b0;
            s1_pixel_q       <= {PIX_W{1'b0}};
            s1_entry_q       <= '0;
            rd_data_q        <= '0;
            wr_en_q          <= 1'b0;
            wr_addr_q        <= {PIX_W{1'b0}};
            wr_data_q        <= '0;
            rd_cnt_q         <= {PIX_W{1'b0}};
            out_valid_q      <= 1'b0;
            out_pixel_q      <= {PIX_W{1'b0}};
            out_last_q       <= 1'b0;
            protocol_error_q <= 1'b0;
        end else begin
            s1_valid_q       <= s1_valid_d;
            s1_first_q       <= s1_first_d;
            s1_pixel_q       <= s1_pixel_d;
            s1_entry_q       <= s1_entry_d;
            rd_data_q        <= rd_data_d;
            wr_en_q          <= wr_en_d;
            wr_addr_q        <= wr_addr_d;
            wr_data_q        <= wr_data_d;
            rd_cnt_q         <= rd_cnt_d;
            out_valid_q      <= out_valid_d;
            out_pixel_q      <= out_pixel_d;
            out_last_q       <= out_last_d;
            protocol_error_q <= protocol_error_d;
        end
    end

    // Line buffer write port; contents are rebuilt by the first pass, so no reset.
    always_ff @(posedge clock) begin
        if (wr_en_q) begin
            mem_q[wr_addr_q] <= wr_data_q;
        end
    end

    assign bus.out_valid      = out_valid_q;
    assign bus.out_pixel      = out_pixel_q;
    assign bus.out_disparity  = rd_data_q.disp;
    assign bus.out_cost       = rd_data_q.cost;
    assign bus.out_last       = out_last_q;
    assign bus.protocol_error = protocol_error_q;

endmodule

// File: tb/tb_disparity_selector.sv
// Scoreboard bench: per-line cost tables drive the sweep, a reference argmin
// fills the expected queue, and a monitor compares every readout sample.
module tb_disparity_selector;
    import disparity_pkg::*;

    logic clock = 1'b0;
    logic reset_n;

    disparity_selector_if bus ();

    disparity_selector dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        int pixel;
        int disp;
        int cost;
        bit last;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] cost_tab [WIDTH][64];

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every presented output sample is matched against the queue head.
    always @(negedge clock) begin
        if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL out_unexpected: got pixel %0d expected no output", bus.out_pixel);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_pixel", longint'(bus.out_pixel), e.pixel);
                check("out_disparity", longint'(bus.out_disparity), e.disp);
                check("out_cost", longint'(bus.out_cost), e.cost);
                check("out_last", longint'(bus.out_last), e.last);
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_idle();
        bus.valid        = 1'b0;
        bus.pixel        = 10'd0;
        bus.clear_buffer = 1'b0;
        bus.disparity_1  = 6'd0;
        bus.disparity_2  = 6'd0;
        bus.disparity_3  = 6'd0;
        bus.disparity_4  = 6'd0;
        bus.cost_1       = 16'd0;
        bus.cost_2       = 16'd0;
        bus.cost_3       = 16'd0;
        bus.cost_4       = 16'd0;
    endtask

    task automatic drive_cand(input int pix, input int d0, input int tab_pix);
        bus.valid       = 1'b1;
        bus.pixel       = 10'(pix);
        bus.disparity_1 = 6'(d0);
        bus.disparity_2 = 6'(d0 + 1);
        bus.disparity_3 = 6'(d0 + 2);
        bus.disparity_4 = 6'(d0 + 3);
        bus.cost_1      = cost_tab[tab_pix][d0];
        bus.cost_2      = cost_tab[tab_pix][d0 + 1];
        bus.cost_3      = cost_tab[tab_pix][d0 + 2];
        bus.cost_4      = cost_tab[tab_pix][d0 + 3];
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_out_valid"}, longint'(bus.out_valid), 0);
        check({tag, "_out_pixel"}, longint'(bus.out_pixel), 0);
        check({tag, "_out_disparity"}, longint'(bus.out_disparity), 0);
        check({tag, "_out_cost"}, longint'(bus.out_cost), 0);
        check({tag, "_out_last"}, longint'(bus.out_last), 0);
        check({tag, "_protocol_error"}, longint'(bus.protocol_error), 0);
    endtask

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic void fill_vshape20();
        for (int p = 0; p < WIDTH; p++)
            for (int d = 0; d < 64; d++)
                cost_tab[p][d] = 16'(iabs(d - 20) * 10);
    endfunction

    function automatic void fill_mix();
        for (int p = 0; p < WIDTH; p++) begin
            int kind = $urandom_range(0, 6);
            int a    = $urandom_range(0, 62);
            int b    = $urandom_range(a + 1, 63);
            int sc   = $urandom_range(1, 50);
            int eq   = $urandom_range(0, 65535);
            for (int d = 0; d < 64; d++) begin
                case (kind)
                    0:       cost_tab[p][d] = 16'(iabs(d - a) * sc);
                    1:       cost_tab[p][d] = 16'(eq);
                    2:       cost_tab[p][d] = (d == p % 64) ? 16'd0 : 16'd100;
                    3:       cost_tab[p][d] = (d == a || d == b) ? 16'd3 : 16'd100;
                    4:       cost_tab[p][d] = (d == a) ? 16'd3 : ((d == b) ? 16'd2 : 16'd100);
                    5:       cost_tab[p][d] = 16'($urandom_range(0, 15));
                    default: cost_tab[p][d] = 16'($urandom_range(0, 65535));
                endcase
            end
        end
    endfunction

    // Reference: the lowest disparity among all those with the smallest cost.
    function automatic void push_expected(input bit directed20);
        for (int p = 0; p < WIDTH; p++) begin
            exp_t e;
            int   best = 0;
            if (directed20) begin
                e = '{p, 20, 0, (p == WIDTH - 1)};
            end else begin
                for (int d = 1; d < 64; d++)
                    if (cost_tab[p][d] < cost_tab[p][best]) best = d;
                e = '{p, best, int'(cost_tab[p][best]), (p == WIDTH - 1)};
            end
            exp_q.push_back(e);
        end
    endfunction

    // One line: 16 passes with a 4-cycle gap, then a full readout window.
    task automatic run_line(input bit directed20, input bit inject, input int reset_pass);
        for (int pass = 0; pass < NUM_PASSES; pass++) begin
            for (int p = 0; p < WIDTH; p++) begin
                if (pass == reset_pass && p == 300) begin
                    drive_idle();
                    reset_n = 1'b0;
                    #1;
                    check_outputs_zero("midline_reset");
                    tick();
                    tick();
                    check_outputs_zero("midline_reset_hold");
                    reset_n = 1'b1;
                    tick();
                    return;
                end
                drive_cand(p, pass * 4, p);
                tick();
                if (inject && pass == 3 && p == 100) begin
                    drive_cand(700, pass * 4, 5);
                    bus.cost_1 = 16'd0;
                    tick();
                    check("range_violation_flag", longint'(bus.protocol_error), 1);
                end
            end
            drive_idle();
            repeat (LINE_GAP) tick();
        end
        tick();
        push_expected(directed20);
        for (int c = 0; c < WIDTH; c++) begin
            drive_idle();
            bus.clear_buffer = 1'b1;
            if (inject && c == 2) begin
                drive_cand(639, 0, 639);
                bus.cost_1 = 16'd5;
                bus.cost_2 = 16'd0;
                bus.cost_3 = 16'd5;
                bus.cost_4 = 16'd5;
            end
            tick();
        end
        drive_idle();
        tick();
        check("out_valid_falls", longint'(bus.out_valid), 0);
        tick();
        check("readout_count", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        drive_idle();
        reset_n = 1'b0;
        tick();
        tick();
        check_outputs_zero("reset");
        reset_n = 1'b1;
        tick();

        fill_vshape20();
        run_line(1'b1, 1'b0, -1);
        check("clean_line_flag", longint'(bus.protocol_error), 0);

        fill_mix();
        run_line(1'b0, 1'b0, -1);
        check("mixed_line_flag", longint'(bus.protocol_error), 0);

        fill_mix();
        for (int d = 0; d < 64; d++) cost_tab[639][d] = 16'd777;
        run_line(1'b0, 1'b1, -1);
        check("sticky_violation_flag", longint'(bus.protocol_error), 1);

        fill_vshape20();
        run_line(1'b1, 1'b0, 7);
        run_line(1'b1, 1'b0, -1);
        check("post_reset_flag", longint'(bus.protocol_error), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
